// File: rtl/ysyx_22050710_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_wb_stage
// Purpose  : Writeback stage of the pipeline. It registers the instruction
//            handed over by the memory stage and, in the following cycle,
//            retires it. Retiring drives the GPR/CSR write ports and the
//            bypass bus back to decode, and bumps the retired-instruction
//            counter. When an ebreak retires, the stage halts and stays
//            halted until reset.
//
// Ports    : i_clk, i_rst_n           clock, asynchronous active-low reset
//            o_ws_allowin             stage can accept (low once halted)
//            i_ms_to_ws_valid/_bus    instruction from the memory stage
//            i_debug_ms_to_ws_bus     {inst, pc, dnpc, memen, memaddr}
//            o_gpr_*                  GPR write port
//            o_csr_*                  CSR write port
//            o_ws_to_ds_bypass_bus    {rd, gpr_data, csr, csr_data}
//            o_retire_cnt             64-bit retired-instruction counter
//            o_halt                   sticky ebreak-retired flag
//            o_commit_*               commit trace (difftest builds only)
//
// Config   : YSYX_22050710_DIFFTEST_EN enables the commit trace outputs and
//            the registered pc/dnpc. When undefined, the commit outputs are
//            tied to zero.
//
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050710_wb_stage #(
  parameter int WORD_WD         = 64,
  parameter int PC_WD           = 64,
  parameter int INST_WD         = 32,
  parameter int GPR_ADDR_WD     = 5,
  parameter int CSR_ADDR_WD     = 12,
  parameter int MS_TO_WS_BUS_WD = 147,
  parameter int BYPASS_BUS_WD   = 145,
  parameter int DEBUG_BUS_WD    = 225
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_ws_allowin,
  input  logic                       i_ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] i_ms_to_ws_bus,
  input  logic [DEBUG_BUS_WD-1:0]    i_debug_ms_to_ws_bus,
  output logic                       o_gpr_wen,
  output logic [GPR_ADDR_WD-1:0]     o_gpr_waddr,
  output logic [WORD_WD-1:0]         o_gpr_wdata,
  output logic                       o_csr_wen,
  output logic [CSR_ADDR_WD-1:0]     o_csr_waddr,
  output logic [WORD_WD-1:0]         o_csr_wdata,
  output logic [BYPASS_BUS_WD-1:0]   o_ws_to_ds_bypass_bus,
  output logic [63:0]                o_retire_cnt,
  output logic                       o_halt,
  output logic                       o_commit_valid,
  output logic [PC_WD-1:0]           o_commit_pc,
  output logic [PC_WD-1:0]           o_commit_dnpc,
  output logic [INST_WD-1:0]         o_commit_inst
);

  localparam logic [INST_WD-1:0] c_EBREAK = INST_WD'(32'h0010_0073);

  // --------------------------------------------------------------------------
  // Incoming bus fields
  // --------------------------------------------------------------------------
  logic                   w_in_gpr_wen;
  logic [GPR_ADDR_WD-1:0] w_in_rd;
  logic [WORD_WD-1:0]     w_in_gpr_result;
  logic                   w_in_csr_wen;
  logic [CSR_ADDR_WD-1:0] w_in_csr;
  logic [WORD_WD-1:0]     w_in_csr_result;

  assign {w_in_gpr_wen, w_in_rd, w_in_gpr_result,
          w_in_csr_wen, w_in_csr, w_in_csr_result} = i_ms_to_ws_bus;

  logic [INST_WD-1:0] w_dbg_inst;
  logic [PC_WD-1:0]   w_dbg_pc;
  logic [PC_WD-1:0]   w_dbg_dnpc;
  logic               w_dbg_memen;
  logic [WORD_WD-1:0] w_dbg_memaddr;

  assign {w_dbg_inst, w_dbg_pc, w_dbg_dnpc, w_dbg_memen, w_dbg_memaddr} =
         i_debug_ms_to_ws_bus;

  // --------------------------------------------------------------------------
  // Handshake: the stage always completes in one cycle, so it can accept
  // whenever it is not halted.
  // --------------------------------------------------------------------------
  logic r_ws_valid;
  logic r_halt;
  logic w_load;

  assign o_ws_allowin = !r_halt;
  assign w_load       = i_ms_to_ws_valid && o_ws_allowin;

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic                   r_gpr_wen;
  logic [GPR_ADDR_WD-1:0] r_rd;
  logic [WORD_WD-1:0]     r_gpr_result;
  logic                   r_csr_wen;
  logic [CSR_ADDR_WD-1:0] r_csr;
  logic [WORD_WD-1:0]     r_csr_result;
  // The instruction word is kept in every build: halt detection needs it
  // even when the rest of the debug bus is not registered.
  logic [INST_WD-1:0]     r_inst;
  logic [63:0]            r_retire_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ws_valid   <= 1'b0;
      r_halt       <= 1'b0;
      r_retire_cnt <= 64'd0;
    end else begin
      // Once halted, nothing new enters; whatever was accepted on the halting
      // edge still retires in the following cycle, then the stage drains.
      r_ws_valid <= o_ws_allowin ? i_ms_to_ws_valid : 1'b0;
      if (r_ws_valid) begin
        r_retire_cnt <= r_retire_cnt + 64'd1;
      end
      if (r_ws_valid && (r_inst == c_EBREAK)) begin
        r_halt <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpr_wen    <= 1'b0;
      r_rd         <= '0;
      r_gpr_result <= '0;
      r_csr_wen    <= 1'b0;
      r_csr        <= '0;
      r_csr_result <= '0;
      r_inst       <= '0;
    end else if (w_load) begin
      r_gpr_wen    <= w_in_gpr_wen;
      r_rd         <= w_in_rd;
      r_gpr_result <= w_in_gpr_result;
      r_csr_wen    <= w_in_csr_wen;
      r_csr        <= w_in_csr;
      r_csr_result <= w_in_csr_result;
      r_inst       <= w_dbg_inst;
    end
  end

  // --------------------------------------------------------------------------
  // Write ports and bypass (combinational from the stage registers)
  // --------------------------------------------------------------------------
  assign o_gpr_wen   = r_ws_valid && r_gpr_wen && (r_rd != '0);
  assign o_gpr_waddr = r_rd;
  assign o_gpr_wdata = r_gpr_result;

  assign o_csr_wen   = r_ws_valid && r_csr_wen;
  assign o_csr_waddr = r_csr;
  assign o_csr_wdata = r_csr_result;

  // Fields are masked by their own write enable so decode never forwards from
  // an instruction that does not write that destination.
  assign o_ws_to_ds_bypass_bus = r_ws_valid ?
         {({GPR_ADDR_WD{r_gpr_wen}} & r_rd),
          ({WORD_WD{r_gpr_wen}}     & r_gpr_result),
          ({CSR_ADDR_WD{r_csr_wen}} & r_csr),
          ({WORD_WD{r_csr_wen}}     & r_csr_result)} : '0;

  assign o_retire_cnt = r_retire_cnt;
  assign o_halt       = r_halt;

  // --------------------------------------------------------------------------
  // Commit trace
  // --------------------------------------------------------------------------
`ifdef YSYX_22050710_DIFFTEST_EN
  logic [PC_WD-1:0] r_pc;
  logic [PC_WD-1:0] r_dnpc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= '0;
      r_dnpc <= '0;
    end else if (w_load) begin
      r_pc   <= w_dbg_pc;
      r_dnpc <= w_dbg_dnpc;
    end
  end

  assign o_commit_valid = r_ws_valid;
  assign o_commit_pc    = r_pc;
  assign o_commit_dnpc  = r_dnpc;
  assign o_commit_inst  = r_inst;

  // Memory-access fields travel on the debug bus but are not traced here.
  logic w_unused_dbg;
  assign w_unused_dbg = ^{w_dbg_memen, w_dbg_memaddr};
`else
  assign o_commit_valid = 1'b0;
  assign o_commit_pc    = '0;
  assign o_commit_dnpc  = '0;
  assign o_commit_inst  = '0;

  logic w_unused_dbg;
  assign w_unused_dbg = ^{w_dbg_pc, w_dbg_dnpc, w_dbg_memen, w_dbg_memaddr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_wb_stage
// Purpose  : Self-checking bench for ysyx_22050710_wb_stage. A transaction
//            model (one slot holding the accepted instruction, a retire
//            count and a halted flag) predicts every output; a compare
//            process checks them on each falling clock edge. Directed
//            sequences with literal expectations pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050710_wb_stage;

  localparam logic [31:0] c_EBREAK = 32'h0010_0073;
  localparam logic [31:0] c_NOP    = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // stimulus fields
  logic        s_valid = 1'b0;
  logic        s_gw    = 1'b0;
  logic [4:0]  s_rd    = '0;
  logic [63:0] s_gd    = '0;
  logic        s_cw    = 1'b0;
  logic [11:0] s_csr   = '0;
  logic [63:0] s_cd    = '0;
  logic [31:0] s_inst  = '0;
  logic [63:0] s_pc    = '0;
  logic [63:0] s_dnpc  = '0;
  logic        s_memen = 1'b0;
  logic [63:0] s_maddr = '0;

  logic [146:0] ms_bus;
  logic [224:0] dbg_bus;
  assign ms_bus  = {s_gw, s_rd, s_gd, s_cw, s_csr, s_cd};
  assign dbg_bus = {s_inst, s_pc, s_dnpc, s_memen, s_maddr};

  logic         o_ws_allowin, o_gpr_wen, o_csr_wen, o_halt, o_commit_valid;
  logic [4:0]   o_gpr_waddr;
  logic [63:0]  o_gpr_wdata, o_csr_wdata, o_retire_cnt, o_commit_pc, o_commit_dnpc;
  logic [11:0]  o_csr_waddr;
  logic [144:0] o_bypass;
  logic [31:0]  o_commit_inst;

  ysyx_22050710_wb_stage dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .o_ws_allowin          (o_ws_allowin),
    .i_ms_to_ws_valid      (s_valid),
    .i_ms_to_ws_bus        (ms_bus),
    .i_debug_ms_to_ws_bus  (dbg_bus),
    .o_gpr_wen             (o_gpr_wen),
    .o_gpr_waddr           (o_gpr_waddr),
    .o_gpr_wdata           (o_gpr_wdata),
    .o_csr_wen             (o_csr_wen),
    .o_csr_waddr           (o_csr_waddr),
    .o_csr_wdata           (o_csr_wdata),
    .o_ws_to_ds_bypass_bus (o_bypass),
    .o_retire_cnt          (o_retire_cnt),
    .o_halt                (o_halt),
    .o_commit_valid        (o_commit_valid),
    .o_commit_pc           (o_commit_pc),
    .o_commit_dnpc         (o_commit_dnpc),
    .o_commit_inst         (o_commit_inst)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: the slot holds the instruction accepted last edge; it
  // retires during the cycle it is visible. An ebreak retiring halts the
  // stage from the next edge; the instruction accepted on that edge still
  // retires, nothing after it does.
  // --------------------------------------------------------------------------
  bit        m_have = 0, m_halted = 0, m_halt_next;
  bit [63:0] m_cnt = 0;
  bit        m_gw = 0, m_cw = 0;
  bit [4:0]  m_rd = 0;
  bit [11:0] m_csr = 0;
  bit [63:0] m_gd = 0, m_cd = 0, m_pc = 0, m_dnpc = 0;
  bit [31:0] m_inst = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 0; m_halted = 0; m_cnt = 0;
      m_gw = 0; m_rd = 0; m_gd = 0; m_cw = 0; m_csr = 0; m_cd = 0;
      m_inst = 0; m_pc = 0; m_dnpc = 0;
    end else begin
      m_halt_next = m_halted || (m_have && m_inst == c_EBREAK);
      if (m_have) m_cnt = m_cnt + 64'd1;
      if (!m_halted && s_valid) begin
        m_have = 1;
        m_gw = s_gw; m_rd = s_rd; m_gd = s_gd;
        m_cw = s_cw; m_csr = s_csr; m_cd = s_cd;
        m_inst = s_inst; m_pc = s_pc; m_dnpc = s_dnpc;
      end else begin
        m_have = 0;
      end
      m_halted = m_halt_next;
    end
  end

  logic [144:0] e_bp;
  bit           cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_bp = m_have ? {(m_gw ? m_rd : 5'd0), (m_gw ? m_gd : 64'd0),
                       (m_cw ? m_csr : 12'd0), (m_cw ? m_cd : 64'd0)} : 145'd0;
      check("m_allowin",   o_ws_allowin, !m_halted);
      check("m_halt",      o_halt, m_halted);
      check("m_cnt",       o_retire_cnt, m_cnt);
      check("m_gpr_wen",   o_gpr_wen, m_have && m_gw && (m_rd != 0));
      check("m_csr_wen",   o_csr_wen, m_have && m_cw);
      check("m_bypass",    o_bypass, e_bp);
      if (m_have) begin
        check("m_gpr_waddr", o_gpr_waddr, m_rd);
        check("m_gpr_wdata", o_gpr_wdata, m_gd);
        check("m_csr_waddr", o_csr_waddr, m_csr);
        check("m_csr_wdata", o_csr_wdata, m_cd);
      end
`ifdef YSYX_22050710_DIFFTEST_EN
      check("m_cvalid", o_commit_valid, m_have);
      if (m_have) begin
        check("m_cpc",   o_commit_pc, m_pc);
        check("m_cdnpc", o_commit_dnpc, m_dnpc);
        check("m_cinst", o_commit_inst, m_inst);
      end
`else
      check("m_commit_zero", {o_commit_valid, o_commit_pc, o_commit_dnpc, o_commit_inst}, '0);
`endif
    end
  end

  // drive one cycle of stimulus, return just after the following falling edge
  task automatic drive(input bit v, input bit gw, input bit [4:0] rd, input bit [63:0] gd,
                       input bit cw, input bit [11:0] csr, input bit [63:0] cd,
                       input bit [31:0] inst);
    s_valid = v; s_gw = gw; s_rd = rd; s_gd = gd;
    s_cw = cw; s_csr = csr; s_cd = cd; s_inst = inst;
    s_pc = {$urandom, $urandom}; s_dnpc = s_pc + 64'd4;
    s_memen = 1'($urandom); s_maddr = {$urandom, $urandom};
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, c_NOP);
  endtask

  initial begin
    // ---------------- reset ----------------
    @(negedge clk);
    cmp_en = 1;
    #1;
    check("rst_all_zero", {o_gpr_wen, o_csr_wen, o_halt, o_retire_cnt, o_bypass, o_commit_valid}, '0);
    check("rst_allowin", o_ws_allowin, 1'b1);
    rst_n = 1'b1;
    idle();
    check("post_rst_allowin", o_ws_allowin, 1'b1);
    check("post_rst_cnt", o_retire_cnt, 64'd0);

    // ---------------- single GPR write ----------------
    drive(1, 1, 5'd5, 64'hDEAD_BEEF, 0, 0, 0, c_NOP);
    check("wr_wen", o_gpr_wen, 1'b1);
    check("wr_waddr", o_gpr_waddr, 5'd5);
    check("wr_wdata", o_gpr_wdata, 64'hDEAD_BEEF);
    idle();
    check("wr_cnt", o_retire_cnt, 64'd1);
    check("wr_wen_off", o_gpr_wen, 1'b0);

    // ---------------- x0 write ----------------
    drive(1, 1, 5'd0, 64'h123, 0, 0, 0, c_NOP);
    check("x0_wen", o_gpr_wen, 1'b0);
    check("x0_bp_rd", o_bypass[144:140], 5'd0);
    check("x0_bp_data", o_bypass[139:76], 64'h123);
    idle();
    check("x0_cnt", o_retire_cnt, 64'd2);

    // ---------------- CSR write ----------------
    drive(1, 0, 5'd7, 64'h55, 1, 12'h305, 64'h8000_0000, c_NOP);
    check("csr_wen", o_csr_wen, 1'b1);
    check("csr_waddr", o_csr_waddr, 12'h305);
    check("csr_wdata", o_csr_wdata, 64'h8000_0000);
    check("csr_bypass", o_bypass, {5'd0, 64'd0, 12'h305, 64'h8000_0000});
    idle();
    check("csr_cnt", o_retire_cnt, 64'd3);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      inst = $urandom;
      if (inst == c_EBREAK) inst = c_NOP;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
            1'($urandom), 12'($urandom), {$urandom, $urandom}, inst);
    end

    // ---------------- reset mid-operation ----------------
    drive(1, 1, 5'd9, 64'hCAFE, 1, 12'h341, 64'h77, c_NOP);
    check("mid_pre_wen", o_gpr_wen, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gwen", o_gpr_wen, 1'b0);
    check("mid_rst_cwen", o_csr_wen, 1'b0);
    check("mid_rst_cnt", o_retire_cnt, 64'd0);
    check("mid_rst_bp", o_bypass, '0);
    s_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("mid_after_cnt", o_retire_cnt, 64'd0);

    // ---------------- counter wrap ----------------
    force dut.r_retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    check("wrap_pre", o_retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 1, 5'd1, 64'h1, 0, 0, 0, c_NOP);
    idle();
    check("wrap_zero", o_retire_cnt, 64'd0);

    // ---------------- ebreak then three valid instructions ----------------
    drive(1, 0, 5'd0, 64'd0, 0, 0, 0, c_EBREAK);
    check("eb_halt0", o_halt, 1'b0);
    drive(1, 1, 5'd3, 64'hAA, 0, 0, 0, c_NOP);
    check("eb_halt1", o_halt, 1'b1);
    check("eb_allowin0", o_ws_allowin, 1'b0);
    check("eb_extra_wen", o_gpr_wen, 1'b1);
    check("eb_cnt1", o_retire_cnt, 64'd1);
    drive(1, 1, 5'd4, 64'hBB, 1, 12'h300, 64'h1, c_NOP);
    check("eb_blk_wen", o_gpr_wen, 1'b0);
    check("eb_cnt2", o_retire_cnt, 64'd2);
    drive(1, 1, 5'd6, 64'hCC, 1, 12'h300, 64'h2, c_NOP);
    check("eb_blk_cwen", o_csr_wen, 1'b0);
    idle();
    check("eb_frozen", o_retire_cnt, 64'd2);
    check("eb_sticky", o_halt, 1'b1);

    // ---------------- reset clears halt ----------------
    rst_n = 1'b0;
    #1;
    check("fin_halt", o_halt, 1'b0);
    check("fin_allowin", o_ws_allowin, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle();
    idle();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
